// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM state encoding and common command bytes.
// Imported by the host transmitter and by the keyboard receive path.
package ps2_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_RTS       = 3'd2;
    localparam logic [2:0] ST_ACK       = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

    function automatic logic ps2_odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser plus a FILTER_LEN-sample glitch filter for one PS/2 pin.
// fall_o pulses for one cycle on each accepted 1->0 transition of the filtered level.
module ps2_line_sync #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic pin_i,
    output logic level_o,
    output logic fall_o
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          fall_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // A new level is taken only after FILTER_LEN consecutive differing samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pin_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            fall_q  <= level_q & ~level_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data + odd parity + stop, ACK check.
// Optional response timeout enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o,
    output logic       inhibit_rx_o,
    output logic       tx_done_o,
    output logic       tx_ack_o,
    output logic       tx_error_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] INH_END  = TW'(INHIBIT_CYCLES);

    logic [2:0]    state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [3:0]    bitcnt_q, bitcnt_d, bitcnt_inc;
    logic [TW-1:0] timer_q, timer_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [1:0]    data_sync_q;
    logic          clk_lvl, clk_fall;

    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .pin_i   (ps2_clk_i),
        .level_o (clk_lvl),
        .fall_o  (clk_fall)
    );

    assign bitcnt_inc = (bitcnt_q == 4'd11) ? bitcnt_q : bitcnt_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_d     = par_q;
        bitcnt_d  = bitcnt_q;
        timer_d   = timer_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        ack_d     = ack_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_valid_i) begin
                    shift_d   = tx_data_i;
                    par_d     = ps2_odd_parity(tx_data_i);
                    bitcnt_d  = 4'd0;
                    timer_d   = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    ack_d     = 1'b0;
                    err_d     = 1'b0;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                end
                // Start bit is already low for one cycle when CLK is released.
                if (timer_q == INH_END) begin
                    clk_oe_d = 1'b0;
                    timer_d  = '0;
                    state_d  = ST_RTS;
                end
            end
            ST_RTS: begin
                if (clk_fall) begin
                    bitcnt_d = bitcnt_inc;
                    if (bitcnt_q < 4'd8) begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = shift_q >> 1;
                    end else if (bitcnt_q == 4'd8) begin
                        data_oe_d = ~par_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    bitcnt_d = bitcnt_inc;
                    ack_d    = ~data_sync_q[1];
                    err_d    = data_sync_q[1];
                    state_d  = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_lvl && data_sync_q[1]) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        if (state_q inside {ST_RTS, ST_ACK, ST_WAIT_IDLE}) begin
            timer_d = timer_q + 1'b1;
            if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                ack_d     = 1'b0;
                err_d     = 1'b1;
                state_d   = ST_DONE;
            end
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            par_q       <= 1'b0;
            bitcnt_q    <= '0;
            timer_q     <= '0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            data_sync_q <= 2'b11;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            bitcnt_q    <= bitcnt_d;
            timer_q     <= timer_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            data_sync_q <= {data_sync_q[0], ps2_data_i};
        end
    end

    assign tx_ready_o    = (state_q == ST_IDLE);
    assign inhibit_rx_o  = (state_q != ST_IDLE);
    assign tx_done_o     = (state_q == ST_DONE);
    assign tx_ack_o      = ack_q;
    assign tx_error_o    = err_q;
    assign ps2_clk_oe_o  = clk_oe_q;
    assign ps2_data_oe_o = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural keyboard that clocks, reads the frame and ACKs.
// Expected frames are built from the byte (LSB first, odd parity, stop 1) and compared bit by bit.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 40;
    localparam int TO  = 3000;
    localparam int FL  = 4;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_valid_i = 1'b0;
    logic       tx_ready_o, ps2_clk_oe_o, ps2_data_oe_o, inhibit_rx_o;
    logic       tx_done_o, tx_ack_o, tx_error_o;
    logic       dev_clk = 1'b1, dev_data = 1'b1, glitch = 1'b0;
    logic       ps2_clk_w, ps2_data_w;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int oe_run = 0;
    int last_run = 0;
    logic last_ack = 1'b0, last_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    assign ps2_clk_w  = dev_clk & ~ps2_clk_oe_o & ~glitch;
    assign ps2_data_w = dev_data & ~ps2_data_oe_o;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .tx_data_i     (tx_data_i),
        .tx_valid_i    (tx_valid_i),
        .tx_ready_o    (tx_ready_o),
        .ps2_clk_i     (ps2_clk_w),
        .ps2_data_i    (ps2_data_w),
        .ps2_clk_oe_o  (ps2_clk_oe_o),
        .ps2_data_oe_o (ps2_data_oe_o),
        .inhibit_rx_o  (inhibit_rx_o),
        .tx_done_o     (tx_done_o),
        .tx_ack_o      (tx_ack_o),
        .tx_error_o    (tx_error_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (tx_done_o) begin
            done_cnt = done_cnt + 1;
            last_ack = tx_ack_o;
            last_err = tx_error_o;
        end
        if (ps2_clk_oe_o) begin
            oe_run = oe_run + 1;
        end else if (oe_run > 0) begin
            last_run = oe_run;
            oe_run = 0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk_i);
            #1;
        end
    endtask

    // One host transfer against the device model; abort_at>0 pulls reset at that clock fall.
    task automatic xfer(input logic [7:0] d, input int hp, input bit do_ack,
                        input int abort_at, input bit do_glitch, input bit busy_pulse);
        logic [9:0] frame;
        logic [9:0] got;
        int d0;
        int n;
        frame = {1'b1, ~^d, d};
        got   = '0;
        d0    = done_cnt;
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        cyc(1);
        tx_valid_i = 1'b0;
        tx_data_i  = ~d;
        chk("accept_clk_oe", ps2_clk_oe_o, 1'b1);
        chk("accept_ready_low", tx_ready_o, 1'b0);
        chk("accept_inhibit_rx", inhibit_rx_o, 1'b1);
        n = 0;
        while (ps2_clk_oe_o && n < INH + 20) begin
            cyc(1);
            n++;
        end
        chk("rts_reached", ps2_clk_oe_o, 1'b0);
        chk("inhibit_len", (last_run >= INH + 1 && last_run <= INH + 2), 1'b1);
        chk("start_bit", ps2_data_w, 1'b0);
        cyc(hp);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && do_ack) begin
                dev_data = 1'b0;
                cyc(8);
            end
            dev_clk = 1'b0;
            if (k == abort_at) begin
                #2;
                rst_n_i = 1'b0;
                #1;
                chk("abort_clk_oe", ps2_clk_oe_o, 1'b0);
                chk("abort_data_oe", ps2_data_oe_o, 1'b0);
                dev_clk = 1'b1;
                cyc(3);
                rst_n_i = 1'b1;
                cyc(2);
                chk("abort_ready", tx_ready_o, 1'b1);
                chk("abort_inhibit_rx", inhibit_rx_o, 1'b0);
                cyc(4 * hp);
                chk("abort_no_done", done_cnt, d0);
                return;
            end
            cyc(hp);
            dev_clk = 1'b1;
            if (k <= 10) got[k-1] = ps2_data_w;
            if (busy_pulse && k == 2) begin
                tx_data_i  = 8'h5A;
                tx_valid_i = 1'b1;
                cyc(1);
                tx_valid_i = 1'b0;
            end
            if (do_glitch && k == 3) begin
                cyc(hp / 2);
                glitch = 1'b1;
                cyc(1);
                glitch = 1'b0;
                cyc(hp / 2);
            end else begin
                cyc(hp);
            end
        end
        dev_data = 1'b1;
        n = 0;
        while (done_cnt == d0 && n < 100) begin
            cyc(1);
            n++;
        end
        chk("done_count", done_cnt, d0 + 1);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("frame_bit%0d_byte%02h", i, d), got[i], frame[i]);
        end
        chk("tx_ack", last_ack, do_ack);
        chk("tx_error", last_err, !do_ack);
        cyc(2);
        chk("post_ready", tx_ready_o, 1'b1);
        chk("post_inhibit_rx", inhibit_rx_o, 1'b0);
        chk("post_clk_oe", ps2_clk_oe_o, 1'b0);
        chk("post_data_oe", ps2_data_oe_o, 1'b0);
    endtask

    initial begin
        int hp;
        int snap;
        int n;
        cyc(3);
        chk("rst_ready", tx_ready_o, 1'b1);
        chk("rst_clk_oe", ps2_clk_oe_o, 1'b0);
        chk("rst_data_oe", ps2_data_oe_o, 1'b0);
        chk("rst_inhibit_rx", inhibit_rx_o, 1'b0);
        chk("rst_done", tx_done_o, 1'b0);
        chk("rst_ack", tx_ack_o, 1'b0);
        chk("rst_error", tx_error_o, 1'b0);
        rst_n_i = 1'b1;
        cyc(5);

        hp = $urandom_range(15, 30);
        xfer(PS2_CMD_SET_LED, hp, 1'b1, 0, 1'b0, 1'b0);
        xfer(8'h07, $urandom_range(15, 30), 1'b1, 0, 1'b0, 1'b0);
        xfer(8'h00, $urandom_range(15, 30), 1'b1, 0, 1'b0, 1'b0);
        xfer(8'($urandom), $urandom_range(15, 30), 1'b0, 0, 1'b0, 1'b0);

        xfer(8'($urandom), $urandom_range(15, 30), 1'b1, 5, 1'b0, 1'b0);
        xfer(PS2_CMD_RESET, $urandom_range(15, 30), 1'b1, 0, 1'b0, 1'b0);

        xfer(8'($urandom), $urandom_range(15, 30), 1'b1, 0, 1'b1, 1'b1);
        snap = done_cnt;
        cyc(3 * INH);
        chk("busy_req_ignored_done", done_cnt, snap);
        chk("busy_req_ignored_clk_oe", ps2_clk_oe_o, 1'b0);

        for (int r = 0; r < 4; r++) begin
            xfer(8'($urandom), $urandom_range(15, 30), 1'($urandom_range(0, 1)), 0, 1'b0, 1'b0);
        end

`ifdef PS2_TX_TIMEOUT_EN
        snap = done_cnt;
        tx_data_i  = PS2_CMD_SET_LED;
        tx_valid_i = 1'b1;
        cyc(1);
        tx_valid_i = 1'b0;
        n = 0;
        while (ps2_clk_oe_o && n < INH + 20) begin
            cyc(1);
            n++;
        end
        chk("to_rts_reached", ps2_clk_oe_o, 1'b0);
        n = 0;
        while (done_cnt == snap && n < TO + 50) begin
            cyc(1);
            n++;
        end
        chk("to_latency", n, TO);
        chk("to_clk_oe", ps2_clk_oe_o, 1'b0);
        chk("to_data_oe", ps2_data_oe_o, 1'b0);
        chk("to_ack", last_ack, 1'b0);
        chk("to_error", last_err, 1'b1);
        cyc(1);
        chk("to_ready", tx_ready_o, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
